multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM.
//
// Sequences fetch, decode, execute, memory and write-back steps for R-type,
// I-arith, load, store and branch instructions over a shared memory that
// completes each access with mem_ready. It also keeps a sticky illegal-opcode
// flag and a wrapping retired-instruction counter.
//
// Parameters:
//   HALT_ON_ILLEGAL  1: undecoded opcode parks the FSM in HALT until reset
//                    0: undecoded opcode returns to FETCH without retiring
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   opcode[6:0]      instruction register opcode field (valid from DECODE)
//   zero             ALU zero flag (branch condition)
//   mem_ready        completion strobe for the current memory access
//   pc_write/pc_src, ir_write, mdr_write, i_or_d, mem_read, mem_write,
//   reg_write, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0]
//                    datapath controls (combinational from state/mem_ready/zero)
//   state[3:0]       current state encoding
//   illegal          sticky undecoded-opcode flag
//   instr_retired    retired-instruction count
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instr_retired
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StExecI  = 4'd3,
        StAddr   = 4'd4,
        StMemRd  = 4'd5,
        StMemWr  = 4'd6,
        StWbAlu  = 4'd7,
        StWbMem  = 4'd8,
        StExecB  = 4'd9,
        StHalt   = 4'd15
    } state_t;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIArith = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic [31:0] retired_q;
    logic        retire;
    logic        set_illegal;

    // Strobes before reset gating.
    logic pc_write_raw, ir_write_raw, mdr_write_raw;
    logic mem_read_raw, mem_write_raw, reg_write_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (retire)      retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mdr_write_raw = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        pc_src        = 1'b0;
        i_or_d        = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;

        case (state_q)
            StFetch: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                // Precompute branch target into ALUOut.
                alu_src_b = 2'b10;
                case (opcode)
                    OpRType:         state_d = StExecR;
                    OpIArith:        state_d = StExecI;
                    OpLoad, OpStore: state_d = StAddr;
                    OpBranch:        state_d = StExecB;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = HALT_ON_ILLEGAL ? StHalt : StFetch;
                    end
                endcase
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StWbAlu;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = StWbAlu;
            end
            StAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OpStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read_raw = 1'b1;
                i_or_d       = 1'b1;
                if (mem_ready) begin
                    mdr_write_raw = 1'b1;
                    state_d       = StWbMem;
                end
            end
            StMemWr: begin
                mem_write_raw = 1'b1;
                i_or_d        = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StWbAlu: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StWbMem: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StExecB: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b01;
                pc_src       = 1'b1;
                pc_write_raw = zero;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StHalt: state_d = StHalt;
            // Unused encodings recover to FETCH.
            default: state_d = StFetch;
        endcase
    end

    // Reset kills strobes immediately, without waiting for a clock edge.
    assign pc_write      = pc_write_raw  & ~reset;
    assign ir_write      = ir_write_raw  & ~reset;
    assign mdr_write     = mdr_write_raw & ~reset;
    assign mem_read      = mem_read_raw  & ~reset;
    assign mem_write     = mem_write_raw & ~reset;
    assign reg_write     = reg_write_raw & ~reset;

    assign state         = state_q;
    assign illegal       = illegal_q;
    assign instr_retired = retired_q;

endmodule
